parity_frame_checker: RTL
=========================

// Module: parity_frame_checker
// PURPOSE
//  Serial receive side of the even-parity link. Deserialises framed bits LSB-first:
//  start(0), DATA_W data bits, parity, stop(1). Checks even parity over data+parity.
//  Presents the word with parity/framing status, and keeps a saturating error count.
//  Sits after the bit-timing logic, which supplies one bit_en strobe per bit period.
// PARAMETERS
//  DATA_W     8   data bits per frame (>=2)
//  ERR_CNT_W  8   width of saturating error counter
// PORTS
//  CLK         in   1          clock, posedge
//  reset_n     in   1          asynchronous, active-low reset
//  D_in        in   1          serial line, idle high
//  bit_en      in   1          sample strobe; D_in is consumed only when 1
//  clr_err     in   1          synchronous clear of err_cnt
//  data_out    out  DATA_W     last received word, LSB = first data bit
//  frame_done  out  1          1-cycle pulse: data_out/status updated
//  parity_err  out  1          last frame had odd 1-count over data+parity
//  frame_err   out  1          last frame had stop bit = 0
//  busy        out  1          1 while in DATA/PARITY/STOP
//  err_cnt     out  ERR_CNT_W  frames with parity_err|frame_err, saturating
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. reset_n=0 -> state IDLE.
//    All outputs 0; shift reg, bit counter and parity acc cleared. Any partial frame is discarded.
//  - No state, counter or register changes on a cycle with bit_en=0.
//  - FSM (all transitions qualified by bit_en=1):
//    IDLE:   D_in=0 -> DATA, bit_cnt<=0, par_acc<=0. D_in=1 -> stay (line idle).
//    DATA:   shreg <= {D_in, shreg[DATA_W-1:1]}; par_acc ^= D_in; bit_cnt++.
//            bit_cnt==DATA_W-1 on this sample -> PARITY.
//    PARITY: par_bad <= par_acc ^ D_in -> STOP.
//    STOP:   data_out<=shreg, parity_err<=par_bad, frame_err<=~D_in,
//            frame_done<=1 -> IDLE.
//  - Latency: frame_done high the cycle after the CLK edge that samples stop; exactly 1 cycle.
//  - data_out/parity_err/frame_err hold until the next frame_done (sticky per frame).
//  - Back-to-back: start bit accepted on the very next bit_en after stop.
//  - bit_cnt width = clog2(DATA_W); no wrap beyond DATA_W-1.
//  - busy = (state != IDLE), registered with state.
//  - err_cnt: +1 on the frame_done update when parity_err|frame_err; holds at 2^ERR_CNT_W-1.
//    clr_err=1 -> 0, with priority over a coincident increment.
//  - A frame with stop=0 is still delivered (data_out updated) and flagged; there is no resync hunt.
// STRUCTURE
//  - parity_pkg: state encoding localparams (IDLE/DATA/PARITY/STOP, 2-bit).
//    Also holds frame constants START_BIT=0, STOP_BIT=1 and function clog2.
//  - Sub-module sat_counter #(W) (inc, clr, q) instantiated for err_cnt; rest flat.
// TESTING (DATA_W=8, ERR_CNT_W=2, bit_en every 4th cycle unless noted)
//  1 Good frame 0xA5: bits 0,1,0,1,0,0,1,0,1,P=0,S=1.
//    -> data_out=0xA5, frame_done 1 cycle, parity_err=0, frame_err=0, err_cnt=0.
//  2 Frame 0x07 with P=0 (odd total) -> parity_err=1, frame_err=0, err_cnt=1, data_out=0x07.
//  3 Frame 0x3C, P=0, S=0 -> frame_err=1, parity_err=0, err_cnt increments, data_out=0x3C.
//  4 reset_n low (mid-cycle) after 4 data bits -> busy=0 and all outputs 0 immediately.
//    Then clean frame 0x3C -> data_out=0x3C, no error.
//  5 Five bad frames -> err_cnt saturates at 3.
//    clr_err asserted on the frame_done-update edge of a bad frame -> err_cnt=0.
//  6 Line held high 50 strobes -> stays IDLE, no frame_done.
//    Good frame with bit_en every cycle and back-to-back second frame 0xFF, P=0 -> two frame_done pulses, no errors.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity serial receiver.
// Contents:
//   state_e    - receiver FSM state encoding (2-bit)
//   START_BIT  - line level of a start bit
//   STOP_BIT   - line level of a valid stop bit
//   clog2()    - width helper for counters, never returns less than 1
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   clock, posedge
//   rst_ni  asynchronous active-low reset
//   inc_i   count up by one unless already at all-ones
//   clr_i   synchronous clear, wins over inc_i
//   q_o     current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] Max = '1;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != Max)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial receive side of the even-parity link. Deserialises LSB-first frames of
// start(0), DATA_W data bits, parity, stop(1), one bit per bit_en strobe, and
// reports the word with parity/framing status plus a saturating error count.
// Ports:
//   CLK         clock, posedge
//   reset_n     asynchronous active-low reset
//   D_in        serial line, idle high
//   bit_en      sample strobe; D_in consumed only when high
//   clr_err     synchronous clear of err_cnt
//   data_out    last received word, LSB = first data bit
//   frame_done  one-cycle pulse when data_out/status update
//   parity_err  last frame had an odd 1-count over data+parity
//   frame_err   last frame had stop bit = 0
//   busy        high while in DATA/PARITY/STOP
//   err_cnt     saturating count of frames with any error
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 D_in,
  input  logic                 bit_en,
  input  logic                 clr_err,
  output logic [DATA_W-1:0]    data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned      CntW    = clog2(DATA_W);
  localparam logic [CntW-1:0]  LastBit = CntW'(DATA_W - 1);

  state_e              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic                par_acc_q;
  logic                par_bad_q;
  logic [DATA_W-1:0]   data_q;
  logic                frame_done_q;
  logic                parity_err_q;
  logic                frame_err_q;
  logic                busy_q;
  logic                err_inc;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // The completion pulse lasts one clock whatever the strobe rate.
      frame_done_q <= 1'b0;
      if (bit_en) begin
        unique case (state_q)
          StIdle: begin
            if (D_in == START_BIT) begin
              state_q   <= StData;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
              par_acc_q <= 1'b0;
            end
          end
          StData: begin
            shreg_q   <= {D_in, shreg_q[DATA_W-1:1]};
            par_acc_q <= par_acc_q ^ D_in;
            if (bit_cnt_q == LastBit) begin
              state_q <= StParity;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          StParity: begin
            par_bad_q <= par_acc_q ^ D_in;
            state_q   <= StStop;
          end
          StStop: begin
            // A bad stop bit still delivers the word; only the flag marks it.
            data_q       <= shreg_q;
            parity_err_q <= par_bad_q;
            frame_err_q  <= (D_in != STOP_BIT);
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Counts on the same edge that publishes the flags of an errored frame.
  assign err_inc = bit_en && (state_q == StStop) && (par_bad_q || (D_in != STOP_BIT));

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk_i  (CLK),
    .rst_ni (reset_n),
    .inc_i  (err_inc),
    .clr_i  (clr_err),
    .q_o    (err_cnt)
  );

  assign data_out   = data_q;
  assign frame_done = frame_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
